// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two
// writeback requesters, with a one-cycle staging register and read forwarding.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] qa_reg,
  output logic              qa_hit,
  output logic [DATA_W-1:0] qa_data,
  input  logic [ADDR_W-1:0] qb_reg,
  output logic              qb_hit,
  output logic [DATA_W-1:0] qb_data
);

  logic              last_b_q, last_b_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              open;
  logic              gnt_a, gnt_b;

  // last_b_q set means B won the previous handshake, so A has priority
  always_comb begin
    open  = ~rst & ~wb_stall;
    gnt_a = open & a_valid & (~b_valid | last_b_q);
    gnt_b = open & b_valid & (~a_valid | ~last_b_q);
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    last_b_d = last_b_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    data_d   = data_q;
    if (gnt_a) begin
      last_b_d = 1'b0;
      we_d     = (a_reg != '0);
      wreg_d   = a_reg;
      data_d   = a_data;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
      we_d     = (b_reg != '0);
      wreg_d   = b_reg;
      data_d   = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      data_q   <= '0;
    end else begin
      last_b_q <= last_b_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      data_q   <= data_d;
    end
  end

  assign RegWrite = we_q;
  assign WriteReg = wreg_q;
  assign DataIn   = data_q;

  // staged write is not yet visible in the register file
  assign qa_hit  = we_q & (wreg_q == qa_reg) & (qa_reg != '0);
  assign qb_hit  = we_q & (wreg_q == qb_reg) & (qb_reg != '0);
  assign qa_data = qa_hit ? data_q : '0;
  assign qb_data = qb_hit ? data_q : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, then random traffic
// checked against a register-file level reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, wb_stall;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_reg, b_reg, WriteReg, qa_reg, qb_reg;
  logic [31:0] a_data, b_data, DataIn, qa_data, qb_data;
  logic        RegWrite, qa_hit, qb_hit;

  int n_chk = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .DataIn(DataIn),
    .qa_reg(qa_reg), .qa_hit(qa_hit), .qa_data(qa_data),
    .qb_reg(qb_reg), .qb_hit(qb_hit), .qb_data(qb_data)
  );

  always #5 clk = ~clk;

  // register file fed by the DUT; it shares the reset and ignores writes during it
  logic [31:0] rf_dut [32] = '{default: 32'h0};
  always @(posedge clk)
    if (!rst && RegWrite) rf_dut[WriteReg] <= DataIn;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, st, av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic [4:0]  qa, qb;
    logic        xar, xbr, xqah;
    logic [31:0] xqad;
    logic        xqbh;
    logic [31:0] xqbd;
    logic        xwe;
    logic [4:0]  xwr;
    logic [31:0] xd;
  } vec_t;

  vec_t tv [23];

  // reference model: committed file, staged write, last winner
  logic [31:0] rf_m [32];
  logic        m_sv, m_last_b;
  logic [4:0]  m_sr;
  logic [31:0] m_sd;
  logic        a_pend, b_pend, ga, gb, eh;
  logic [4:0]  a_r, b_r;
  logic [31:0] a_d, b_d, seen, want;

  initial begin
    tv[0]  = '{1,0,1,5,32'h1234,1,4,32'hB,0,0, 0,0,0,0,0,0, 0,0,0};
    tv[1]  = '{0,0,1,5,32'h1234,0,0,0,5,0, 1,0,0,0,0,0, 1,5,32'h1234};
    tv[2]  = '{0,0,0,0,0,0,0,0,5,0, 0,0,1,32'h1234,0,0, 0,5,32'h1234};
    tv[3]  = '{0,0,0,0,0,1,0,32'hDEAD,0,0, 0,1,0,0,0,0, 0,0,32'hDEAD};
    tv[4]  = '{0,0,1,3,32'hA0,1,4,32'hB0,0,0, 1,0,0,0,0,0, 1,3,32'hA0};
    tv[5]  = '{0,0,1,3,32'hA1,1,4,32'hB0,3,4, 0,1,1,32'hA0,0,0, 1,4,32'hB0};
    tv[6]  = '{0,0,1,3,32'hA1,1,4,32'hB1,3,4, 1,0,0,0,1,32'hB0, 1,3,32'hA1};
    tv[7]  = '{0,0,1,3,32'hA2,1,4,32'hB1,0,0, 0,1,0,0,0,0, 1,4,32'hB1};
    tv[8]  = '{0,0,1,9,32'h55AA,0,0,0,0,0, 1,0,0,0,0,0, 1,9,32'h55AA};
    tv[9]  = '{0,0,0,0,0,0,0,0,9,8, 0,0,1,32'h55AA,0,0, 0,9,32'h55AA};
    tv[10] = '{0,0,0,0,0,0,0,0,9,9, 0,0,0,0,0,0, 0,9,32'h55AA};
    tv[11] = '{0,1,1,6,32'h66,0,0,0,9,0, 0,0,0,0,0,0, 0,9,32'h55AA};
    tv[12] = tv[11];
    tv[13] = tv[11];
    tv[14] = '{0,0,1,6,32'h66,0,0,0,0,0, 1,0,0,0,0,0, 1,6,32'h66};
    tv[15] = '{0,1,1,2,32'h22,0,0,0,6,0, 0,0,1,32'h66,0,0, 0,6,32'h66};
    tv[16] = '{0,0,1,2,32'h22,0,0,0,6,0, 1,0,0,0,0,0, 1,2,32'h22};
    tv[17] = '{0,0,1,7,32'h77,0,0,0,0,0, 1,0,0,0,0,0, 1,7,32'h77};
    tv[18] = '{1,0,0,0,0,0,0,0,7,0, 0,0,1,32'h77,0,0, 0,0,0};
    tv[19] = '{0,0,0,0,0,0,0,0,7,0, 0,0,0,0,0,0, 0,0,0};
    tv[20] = '{0,0,1,1,32'h11,1,1,32'h12,0,0, 1,0,0,0,0,0, 1,1,32'h11};
    tv[21] = '{0,0,0,0,0,1,1,32'h12,1,0, 0,1,1,32'h11,0,0, 1,1,32'h12};
    tv[22] = '{0,0,0,0,0,0,0,0,1,0, 0,0,1,32'h12,0,0, 0,1,32'h12};

    rst = 1; wb_stall = 0; a_valid = 0; b_valid = 0;
    a_reg = 0; b_reg = 0; a_data = 0; b_data = 0; qa_reg = 0; qb_reg = 0;
    @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = tv[i].rst; wb_stall = tv[i].st;
      a_valid = tv[i].av; a_reg = tv[i].ar; a_data = tv[i].ad;
      b_valid = tv[i].bv; b_reg = tv[i].br; b_data = tv[i].bd;
      qa_reg = tv[i].qa; qb_reg = tv[i].qb;
      #1;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(tv[i].xar));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(tv[i].xbr));
      chk($sformatf("v%0d qa_hit", i), 32'(qa_hit), 32'(tv[i].xqah));
      chk($sformatf("v%0d qa_data", i), qa_data, tv[i].xqad);
      chk($sformatf("v%0d qb_hit", i), 32'(qb_hit), 32'(tv[i].xqbh));
      chk($sformatf("v%0d qb_data", i), qb_data, tv[i].xqbd);
      @(posedge clk); #1;
      chk($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(tv[i].xwe));
      chk($sformatf("v%0d WriteReg", i), 32'(WriteReg), 32'(tv[i].xwr));
      chk($sformatf("v%0d DataIn", i), DataIn, tv[i].xd);
    end

    // the write to r7 discarded by reset must never reach the file
    chk("rst_drop r7", rf_dut[7], 32'h0);
    chk("r0 untouched", rf_dut[0], 32'h0);

    foreach (rf_m[k]) rf_m[k] = 32'h0;
    rf_m[1] = 32'h12; rf_m[2] = 32'h22; rf_m[3] = 32'hA1; rf_m[4] = 32'hB1;
    rf_m[5] = 32'h1234; rf_m[6] = 32'h66; rf_m[9] = 32'h55AA;
    m_sv = 0; m_sr = 0; m_sd = 0; m_last_b = 1;
    a_pend = 0; b_pend = 0; a_r = 0; b_r = 0; a_d = 0; b_d = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!a_pend) begin
        if ($urandom_range(9) < 6) begin
          a_pend = 1; a_r = 5'($urandom_range(9)); a_d = $urandom;
        end
      end else if ($urandom_range(19) == 0) a_pend = 0;
      if (!b_pend) begin
        if ($urandom_range(9) < 6) begin
          b_pend = 1; b_r = 5'($urandom_range(9)); b_d = $urandom;
        end
      end else if ($urandom_range(19) == 0) b_pend = 0;
      rst = (c == 0) || ($urandom_range(99) == 0);
      wb_stall = ($urandom_range(4) == 0);
      a_valid = a_pend; a_reg = a_r; a_data = a_d;
      b_valid = b_pend; b_reg = b_r; b_data = b_d;
      qa_reg = 5'($urandom_range(9)); qb_reg = 5'($urandom_range(9));
      #1;
      // both pending: the one that did not win last time goes first
      ga = 0; gb = 0;
      if (!rst && !wb_stall) begin
        if (a_pend && b_pend) begin
          if (m_last_b) ga = 1; else gb = 1;
        end else begin
          ga = a_pend; gb = b_pend;
        end
      end
      chk("rnd a_ready", 32'(a_ready), 32'(ga));
      chk("rnd b_ready", 32'(b_ready), 32'(gb));
      eh = m_sv && m_sr != 0 && m_sr == qa_reg;
      chk("rnd qa_hit", 32'(qa_hit), 32'(eh));
      chk("rnd qa_data", qa_data, eh ? m_sd : 32'h0);
      seen = qa_hit ? qa_data : rf_dut[qa_reg];
      want = eh ? m_sd : rf_m[qa_reg];
      chk("rnd read_a", seen, want);
      eh = m_sv && m_sr != 0 && m_sr == qb_reg;
      chk("rnd qb_hit", 32'(qb_hit), 32'(eh));
      seen = qb_hit ? qb_data : rf_dut[qb_reg];
      want = eh ? m_sd : rf_m[qb_reg];
      chk("rnd read_b", seen, want);
      @(posedge clk);
      if (rst) begin
        m_sv = 0; m_sr = 0; m_sd = 0; m_last_b = 1;
      end else begin
        if (m_sv && m_sr != 0) rf_m[m_sr] = m_sd;
        m_sv = ga || gb;
        if (ga) begin
          m_sr = a_r; m_sd = a_d; m_last_b = 0; a_pend = 0;
        end else if (gb) begin
          m_sr = b_r; m_sd = b_d; m_last_b = 1; b_pend = 0;
        end
      end
      #1;
      chk("rnd RegWrite", 32'(RegWrite), 32'(m_sv && m_sr != 0));
      chk("rnd WriteReg", 32'(WriteReg), 32'(m_sr));
      chk("rnd DataIn", DataIn, m_sd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU/main pipe) and B (load / multi-cycle MUL-DIV unit). Each requester uses a valid/ready handshake, and contention is resolved round-robin. The winning write is registered one cycle before it reaches the register file's RegWrite/WriteReg/DataIn inputs. Two read-side queries receive forwarded data for a write that is staged but not yet committed.

Parameters:
DATA_W, 32, width of write data and forwarded data
ADDR_W, 5, width of register index (32 registers)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
wb_stall  in  1  when 1, no new grants this cycle
a_valid  in  1  requester A has a write pending
a_ready  out  1  A's write accepted this cycle (combinational)
a_reg  in  ADDR_W  A's destination register
a_data  in  DATA_W  A's write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B's write accepted this cycle (combinational)
b_reg  in  ADDR_W  B's destination register
b_data  in  DATA_W  B's write data
RegWrite  out  1  registered write enable to register file
WriteReg  out  ADDR_W  registered destination index to register file
DataIn  out  DATA_W  registered write data to register file
qa_reg  in  ADDR_W  read-port A index to check for forwarding
qa_hit  out  1  staged write matches qa_reg (combinational)
qa_data  out  DATA_W  staged data when qa_hit, else 0
qb_reg  in  ADDR_W  read-port B index to check for forwarding
qb_hit  out  1  staged write matches qb_reg (combinational)
qb_data  out  DATA_W  staged data when qb_hit, else 0

Behaviour:
- Reset (rst=1 at posedge): RegWrite=0, WriteReg=0, DataIn=0, last_grant=B. While rst=1, a_ready=b_ready=0.
- Grant (combinational):
  - If wb_stall=1: no grant.
  - Else if only one valid: grant that requester.
  - Else if both valid: grant the requester that is not last_grant, so A wins the first conflict after reset.
  - ready=1 only for the granted requester. A handshake completes when valid&ready are both 1 at a posedge.
- last_grant updates only on a completed handshake. It does not change on idle or stalled cycles.
- Output stage, at each posedge:
  - On a grant: WriteReg<=granted reg, DataIn<=granted data, RegWrite<=1 if granted reg!=0, else 0.
  - Writes to register 0 are accepted (ready=1) and consume the grant, but never raise RegWrite.
  - No grant: RegWrite<=0. WriteReg and DataIn hold their previous values.
- Latency: a handshake at edge N gives RegWrite=1 during cycle N+1. The register file commits at edge N+1. Throughput is one write per cycle.
- No backpressure from the register file; the output stage never blocks.
- Forwarding: qX_hit = RegWrite & (WriteReg==qX_reg) & (qX_reg!=0). qX_data = DataIn when hit, else 0. This covers the one cycle in which the register file still returns the stale value.
- Same destination from A and B in the same cycle: the round-robin order decides commit order. No merging.
- A requester must hold valid, reg and data stable until ready. Dropping valid before ready is permitted; nothing is written.
- rst asserted while a write is staged: the staged write is discarded (RegWrite=0 after the edge). A and B must re-present their writes.
- wb_stall=1 while a write is staged: the staged write still commits. Only new grants are blocked.

Test Plan:
- Reset: rst=1 for 2 cycles → RegWrite=0, WriteReg=0, DataIn=0, a_ready=b_ready=0. After release, a_valid=1 with reg 5, data 0x1234 → a_ready=1; next cycle RegWrite=1, WriteReg=5, DataIn=0x1234.
- Round-robin: A and B valid continuously for 4 cycles (A→r3/0xA0..., B→r4/0xB0...) → grants A,B,A,B. RegWrite stays 1 every cycle with alternating WriteReg 3,4,3,4.
- Register zero: b_valid=1, b_reg=0, data 0xDEAD → b_ready=1; next cycle RegWrite=0, and qa_reg=0 gives qa_hit=0. last_grant becomes B, so a following A/B conflict grants A.
- Forwarding: A writes r9=0x55AA → in the following cycle qa_reg=9 gives qa_hit=1, qa_data=0x55AA, while qb_reg=8 gives qb_hit=0, qb_data=0. One cycle later both hits are 0.
- Stall: a_valid=1 with wb_stall=1 for 3 cycles → a_ready=0, RegWrite=0. Drop stall → A is granted, with RegWrite=1 the next cycle. Stall asserted while a write is staged → that write still shows RegWrite=1.
- Reset mid-operation: A is granted r7=0x77 at edge N and rst=1 at edge N+1 → RegWrite=0 after edge N+1, and the register file sees no committed write to r7.
